mole_round_ctrl: RTL

Round sequencer for the 4x4 whack-a-mole game. Picks a pseudo-random cell and colour, enables the game matrix display on it, and times the player's response window. On a hit it runs the display's boom animation and scores the hit; on a wrong key or timeout it deducts a life. It sits between the key decoder and the game matrix display, and drives that display's `en`, `pos`, `color` and `showBoom` inputs directly.

---
 rtl/game_pkg.sv | 41 ++++
 rtl/mole_round_ctrl_lfsr8.sv | 35 +++
 rtl/mole_round_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Package : game_pkg
//  Shared types and constants for the whack-a-mole round sequencer:
//  state encoding, display colour codes, and the LFSR seed/tap mask.
//  Revision: 1.0
// ============================================================================
package game_pkg;

  // Round sequencer states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPAWN    = 3'd1,
    WAIT_HIT = 3'd2,
    BOOM     = 3'd3,
    MISS     = 3'd4,
    OVER     = 3'd5
  } state_t;

  // Display colour codes; OFF is never shown while the display is enabled
  localparam logic [1:0] OFF = 2'b00;
  localparam logic [1:0] C1  = 2'b01;
  localparam logic [1:0] C2  = 2'b10;
  localparam logic [1:0] C3  = 2'b11;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bit positions 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // One LFSR advance: shift left, feedback parity of tapped bits into bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

  // Colour rotation C1 -> C2 -> C3 -> C1; OFF is folded back to C1
  function automatic logic [1:0] color_next(input logic [1:0] c);
    return ((c == C3) || (c == OFF)) ? C1 : (c + 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mole_round_ctrl_lfsr8.sv
`default_nettype none
// ============================================================================
//  Module  : lfsr8
//  Free-running 8-bit Fibonacci LFSR. Advances once per cycle, or twice
//  when step2 is high. A non-zero seed keeps it out of the all-zero state.
//  Revision: 1.0
// ============================================================================
module lfsr8
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step2,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic [7:0] w_one;
  logic [7:0] w_two;

  assign w_one = lfsr_next(r_q);
  assign w_two = lfsr_next(w_one);
  assign q     = r_q;

  // Shift register: one step normally, two steps when the extra advance is requested
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= LFSR_SEED;
    end else begin
      r_q <= step2 ? w_two : w_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mole_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : mole_round_ctrl
//  Round sequencer for the 4x4 whack-a-mole game. Spawns a pseudo-random
//  target, times the response window, runs the boom animation on a hit,
//  deducts a life on a miss/timeout, and tracks score and lives.
//  Revision: 1.0
// ============================================================================
module mole_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned WIN_INIT = 20_000_000,
  parameter int unsigned WIN_STEP = 2_000_000,
  parameter int unsigned WIN_MIN  = 4_000_000,
  parameter int unsigned GAP      = 5_000_000,
  parameter int unsigned LIVES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key_pos,
  input  logic       finish_boom,
  output logic       disp_en,
  output logic [3:0] pos,
  output logic [1:0] color,
  output logic       show_boom,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam logic [24:0] c_WIN_INIT   = 25'(WIN_INIT);
  localparam logic [24:0] c_WIN_STEP   = 25'(WIN_STEP);
  localparam logic [24:0] c_WIN_MIN    = 25'(WIN_MIN);
  localparam logic [24:0] c_GAP_LOAD   = 25'(GAP - 1);
  localparam logic [25:0] c_WIN_THRESH = 26'(WIN_MIN) + 26'(WIN_STEP);
  localparam logic [2:0]  c_LIVES      = 3'(LIVES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_first;      // high during the first cycle spent in a state
  logic [24:0] r_cnt;        // window / gap down-counter
  logic [24:0] r_window;     // current response window
  logic [1:0]  r_hits;       // hits modulo 4, drives window shrink
  logic [7:0]  r_score;
  logic [2:0]  r_lives;
  logic [3:0]  r_pos;
  logic [1:0]  r_color;
  logic        r_disp_en;
  logic        r_show_boom;
  logic        r_game_over;

  logic [7:0]  w_lfsr;
  logic [3:0]  w_cand;
  logic [3:0]  w_lfsr_hi_unused;
  logic        w_reload;
  logic        w_take;
  logic        w_score_evt;
  logic        w_miss_evt;
  logic [2:0]  w_lives_after;
  logic [24:0] w_win_dec;

  lfsr8 u_lfsr8 (
    .clk   (clk),
    .rst   (rst),
    .step2 (r_state == SPAWN),
    .q     (w_lfsr)
  );

  assign {w_lfsr_hi_unused, w_cand} = w_lfsr;

  // First-cycle actions of BOOM and MISS
  assign w_score_evt   = (r_state == BOOM) && r_first;
  assign w_miss_evt    = (r_state == MISS) && r_first;
  assign w_lives_after = w_miss_evt ? (r_lives - 3'd1) : r_lives;

  // Shrunk window, clamped at the floor without wrapping below zero
  assign w_win_dec = ({1'b0, r_window} >= c_WIN_THRESH) ? (r_window - c_WIN_STEP) : c_WIN_MIN;

  // Next-state decode plus the reload/latch strobes that accompany transitions
  always_comb begin
    w_state_nxt = r_state;
    w_reload    = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        if (start) begin
          w_state_nxt = SPAWN;
          w_reload    = 1'b1;
        end
      end
      SPAWN: begin
        if (w_cand != r_pos) begin
          w_state_nxt = WAIT_HIT;
          w_take      = 1'b1;
        end
      end
      WAIT_HIT: begin
        // A key in the final window cycle takes priority over the timeout
        if (key_valid) begin
          w_state_nxt = (key_pos == r_pos) ? BOOM : MISS;
        end else if (r_cnt == 25'd0) begin
          w_state_nxt = MISS;
        end
      end
      BOOM: begin
        if (!r_first && finish_boom) begin
          w_state_nxt = SPAWN;
        end
      end
      MISS: begin
        if (r_cnt == 25'd0) begin
          w_state_nxt = (w_lives_after == 3'd0) ? OVER : SPAWN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register and first-cycle marker
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_first <= (w_state_nxt != r_state);
    end
  end

  // Down-counter: loaded with window-1 on spawn and GAP-1 on MISS entry, so
  // the state lasts exactly that many cycles before the zero test fires
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 25'd0;
    end else if (w_take) begin
      r_cnt <= r_window - 25'd1;
    end else if ((w_state_nxt == MISS) && (r_state != MISS)) begin
      r_cnt <= c_GAP_LOAD;
    end else if (((r_state == WAIT_HIT) || (r_state == MISS)) && (r_cnt != 25'd0)) begin
      r_cnt <= r_cnt - 25'd1;
    end
  end

  // Score, lives, hit counter and window, reloaded at the start of each game
  always_ff @(posedge clk) begin
    if (rst || w_reload) begin
      r_score  <= 8'd0;
      r_lives  <= c_LIVES;
      r_hits   <= 2'd0;
      r_window <= c_WIN_INIT;
    end else begin
      if (w_score_evt) begin
        if (r_score != 8'hFF) begin
          r_score <= r_score + 8'd1;
        end
        r_hits <= r_hits + 2'd1;
        if (r_hits == 2'd3) begin
          r_window <= w_win_dec;
        end
      end
      if (w_miss_evt) begin
        r_lives <= w_lives_after;
      end
    end
  end

  // Target cell and colour, latched when a spawn candidate is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos   <= 4'd0;
      r_color <= C3;
    end else if (w_take) begin
      r_pos   <= w_cand;
      r_color <= color_next(r_color);
    end
  end

  // Display controls registered from the next state so they track it exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_en   <= 1'b0;
      r_show_boom <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_disp_en   <= (w_state_nxt == WAIT_HIT) || (w_state_nxt == BOOM);
      r_show_boom <= (w_state_nxt == BOOM);
      r_game_over <= (w_state_nxt == OVER);
    end
  end

  assign disp_en   = r_disp_en;
  assign pos       = r_pos;
  assign color     = r_color;
  assign show_boom = r_show_boom;
  assign score     = r_score;
  assign lives     = r_lives;
  assign game_over = r_game_over;

endmodule
`default_nettype wire
